// File: rtl/timer_peripheral.sv
// Memory-mapped timer / LED / switch / 7-segment register block on the CPU data bus.
// The interval timer reloads TL from TH on overflow and raises a sticky, maskable interrupt.
module timer_peripheral #(
  parameter int TIMER_W = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rd,
  input  logic        wr,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  input  logic [7:0]  switch,
  output logic [7:0]  led,
  output logic [11:0] digi,
  output logic        irqout
);

  localparam logic [2:0] OFF_TH   = 3'd0;
  localparam logic [2:0] OFF_TL   = 3'd1;
  localparam logic [2:0] OFF_TCON = 3'd2;
  localparam logic [2:0] OFF_LED  = 3'd3;
  localparam logic [2:0] OFF_SW   = 3'd4;
  localparam logic [2:0] OFF_DIGI = 3'd5;

  logic [TIMER_W-1:0] th_q, th_d;
  logic [TIMER_W-1:0] tl_q, tl_d;
  logic [2:0]         tcon_q, tcon_d;
  logic [7:0]         led_q, led_d;
  logic [11:0]        digi_q, digi_d;

  logic       sel;
  logic [2:0] off;
  logic       wr_sel;
  logic       overflow;
  logic       status_set;

  // Address bits outside the decoded window are intentionally ignored.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{addr[27:5], addr[1:0]};

  assign sel        = (addr[31:28] == 4'h4);
  assign off        = addr[4:2];
  assign wr_sel     = wr & sel;
  assign overflow   = tcon_q[0] & (&tl_q);
  assign status_set = overflow & tcon_q[1];

  always_comb begin
    th_d   = th_q;
    tl_d   = tl_q;
    tcon_d = tcon_q;
    led_d  = led_q;
    digi_d = digi_q;

    // Timer update first; a CPU write below overrides it for the same register.
    if (tcon_q[0]) begin
      tl_d = overflow ? th_q : tl_q + 1'b1;
    end
    if (status_set) begin
      tcon_d[2] = 1'b1;
    end

    if (wr_sel) begin
      case (off)
        OFF_TH:   th_d   = wdata[TIMER_W-1:0];
        OFF_TL:   tl_d   = wdata[TIMER_W-1:0];
        OFF_TCON: tcon_d = wdata[2:0];
        OFF_LED:  led_d  = wdata[7:0];
        OFF_DIGI: digi_d = wdata[11:0];
        default:  ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      th_q   <= '0;
      tl_q   <= '0;
      tcon_q <= 3'b000;
      led_q  <= 8'h00;
      digi_q <= 12'h000;
    end else begin
      th_q   <= th_d;
      tl_q   <= tl_d;
      tcon_q <= tcon_d;
      led_q  <= led_d;
      digi_q <= digi_d;
    end
  end

  // Reads see the registered (pre-write) values, so rd+wr to one register returns the old value.
  always_comb begin
    rdata = 32'h0;
    if (rd && sel) begin
      case (off)
        OFF_TH:   rdata = 32'(th_q);
        OFF_TL:   rdata = 32'(tl_q);
        OFF_TCON: rdata = {29'h0, tcon_q};
        OFF_LED:  rdata = {24'h0, led_q};
        OFF_SW:   rdata = {24'h0, switch};
        OFF_DIGI: rdata = {20'h0, digi_q};
        default:  rdata = 32'h0;
      endcase
    end
  end

  assign led    = led_q;
  assign digi   = digi_q;
  assign irqout = tcon_q[1] & tcon_q[2];

endmodule

// File: tb/tb_timer_peripheral.sv
// Self-checking bench for timer_peripheral: register map, reload period, interrupt
// masking/clearing, write-vs-overflow collisions and mid-count reset.
module tb_timer_peripheral;

  localparam logic [31:0] BASE = 32'h4000_0000;
  localparam logic [31:0] A_TH   = BASE + 32'h00;
  localparam logic [31:0] A_TL   = BASE + 32'h04;
  localparam logic [31:0] A_TCON = BASE + 32'h08;
  localparam logic [31:0] A_LED  = BASE + 32'h0C;
  localparam logic [31:0] A_SW   = BASE + 32'h10;
  localparam logic [31:0] A_DIGI = BASE + 32'h14;

  logic        clk;
  logic        reset;
  logic        rd;
  logic        wr;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic [7:0]  switch;
  logic [7:0]  led;
  logic [11:0] digi;
  logic        irqout;

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] exp_q[$];

  timer_peripheral #(.TIMER_W(32)) dut (
    .clk    (clk),
    .reset  (reset),
    .rd     (rd),
    .wr     (wr),
    .addr   (addr),
    .wdata  (wdata),
    .rdata  (rdata),
    .switch (switch),
    .led    (led),
    .digi   (digi),
    .irqout (irqout)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One rising edge; inputs change 1 time unit after it.
  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    addr  = a;
    wdata = d;
    wr    = 1'b1;
    tick();
    wr    = 1'b0;
  endtask

  // Push the expectation, drive a combinational read, then pop and compare.
  task automatic expect_read(input string tag, input logic [31:0] a, input logic [31:0] exp);
    logic [31:0] got;
    exp_q.push_back(exp);
    addr = a;
    rd   = 1'b1;
    #2;
    got  = rdata;
    rd   = 1'b0;
    check(tag, got, exp_q.pop_front());
  endtask

  initial begin
    reset  = 1'b1;
    rd     = 1'b0;
    wr     = 1'b0;
    addr   = 32'h0;
    wdata  = 32'h0;
    switch = 8'h00;
    tick(2);
    reset = 1'b0;

    // Reset state across every decoded offset
    for (int i = 0; i < 8; i++) begin
      expect_read($sformatf("rst_rd_%0d", i), BASE + 32'(i * 4), 32'h0);
    end
    check("rst_irq", 32'(irqout), 32'h0);
    check("rst_led", 32'(led), 32'h0);
    check("rst_digi", 32'(digi), 32'h0);

    // Reload and interrupt period
    bus_write(A_TH, 32'hFFFF_FFF0);
    bus_write(A_TL, 32'hFFFF_FFFF);
    bus_write(A_TCON, 32'h3);
    expect_read("pre_ovf_tl", A_TL, 32'hFFFF_FFFF);
    check("pre_ovf_irq", 32'(irqout), 32'h0);
    tick();
    expect_read("ovf1_tl", A_TL, 32'hFFFF_FFF0);
    expect_read("ovf1_tcon", A_TCON, 32'h7);
    check("ovf1_irq", 32'(irqout), 32'h1);
    tick(15);
    expect_read("p15_tl", A_TL, 32'hFFFF_FFFF);
    tick();
    expect_read("p16_tl", A_TL, 32'hFFFF_FFF0);
    check("p16_irq", 32'(irqout), 32'h1);

    // Mask the interrupt: counting continues, no status set
    bus_write(A_TCON, 32'h1);
    check("mask_irq", 32'(irqout), 32'h0);
    expect_read("mask_tl", A_TL, 32'hFFFF_FFF1);
    tick(15);
    expect_read("mask_ovf_tl", A_TL, 32'hFFFF_FFF0);
    expect_read("mask_ovf_tcon", A_TCON, 32'h1);
    check("mask_ovf_irq", 32'(irqout), 32'h0);
    bus_write(A_TCON, 32'h3);
    tick(13);
    expect_read("rearm_tl", A_TL, 32'hFFFF_FFFE);
    check("rearm_irq0", 32'(irqout), 32'h0);
    tick();
    check("rearm_irq1", 32'(irqout), 32'h0);
    tick();
    check("rearm_irq2", 32'(irqout), 32'h1);

    // TCON write on the overflow edge drops the status set
    bus_write(A_TCON, 32'h3);
    check("clr_irq", 32'(irqout), 32'h0);
    tick(14);
    expect_read("col1_pre_tl", A_TL, 32'hFFFF_FFFF);
    bus_write(A_TCON, 32'h1);
    expect_read("col1_tcon", A_TCON, 32'h1);
    expect_read("col1_tl", A_TL, 32'hFFFF_FFF0);
    check("col1_irq", 32'(irqout), 32'h0);

    // TL write on the overflow edge wins over reload; status still sets
    bus_write(A_TCON, 32'h3);
    tick(14);
    expect_read("col2_pre_tl", A_TL, 32'hFFFF_FFFF);
    bus_write(A_TL, 32'h1234_5678);
    expect_read("col2_tl", A_TL, 32'h1234_5678);
    expect_read("col2_tcon", A_TCON, 32'h7);
    check("col2_irq", 32'(irqout), 32'h1);

    // Stop the timer; TL increments on this edge then holds
    bus_write(A_TCON, 32'h0);
    check("stop_irq", 32'(irqout), 32'h0);

    // Register file
    bus_write(A_LED, 32'h0000_00A5);
    check("led_out", 32'(led), 32'hA5);
    bus_write(A_DIGI, 32'h0000_0E79);
    check("digi_out", 32'(digi), 32'hE79);
    expect_read("led_rd", A_LED, 32'hA5);
    expect_read("digi_rd", A_DIGI, 32'hE79);
    switch = 8'h3C;
    bus_write(A_SW, 32'hFFFF_FFFF);
    expect_read("sw_rd", A_SW, 32'h3C);
    expect_read("off18_rd", BASE + 32'h18, 32'h0);
    bus_write(32'h5000_000C, 32'h11);
    check("nosel_led", 32'(led), 32'hA5);
    expect_read("nosel_rd", 32'h5000_000C, 32'h0);

    // Simultaneous read and write returns the pre-write value
    exp_q.push_back(32'hA5);
    addr  = A_LED;
    wdata = 32'h5A;
    rd    = 1'b1;
    wr    = 1'b1;
    #2;
    check("rdwr_old", rdata, exp_q.pop_front());
    tick();
    rd = 1'b0;
    wr = 1'b0;
    check("rdwr_new", 32'(led), 32'h5A);
    expect_read("stop_tl_hold", A_TL, 32'h1234_5679);

    // TH write leaves TL alone
    bus_write(A_TL, 32'hFFFF_FFFE);
    bus_write(A_TH, 32'hFFFF_FFF0);
    expect_read("th_wr_tl", A_TL, 32'hFFFF_FFFE);

    // Reset mid-count with the interrupt pending
    bus_write(A_TCON, 32'h3);
    tick(2);
    check("prerst_irq", 32'(irqout), 32'h1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    expect_read("mrst_th", A_TH, 32'h0);
    expect_read("mrst_tl", A_TL, 32'h0);
    expect_read("mrst_tcon", A_TCON, 32'h0);
    expect_read("mrst_led", A_LED, 32'h0);
    expect_read("mrst_digi", A_DIGI, 32'h0);
    check("mrst_irq", 32'(irqout), 32'h0);
    check("mrst_led_o", 32'(led), 32'h0);
    check("mrst_digi_o", 32'(digi), 32'h0);
    tick(5);
    expect_read("mrst_tl_hold", A_TL, 32'h0);

    if (exp_q.size() != 0) begin
      check("sb_drain", 32'(exp_q.size()), 32'h0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
